capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Write-side sequencer for the sample FIFO.
- Sits between the ADC sample stream and the FIFO write pointer, in the write clock domain.
- Arms on command, writes a programmable number of pre-trigger samples, then waits for a level-crossing trigger, then writes a programmable number of post-trigger samples and stops.
- Reports busy/triggered/done/overflow status to the host interface.

Parameters:
DATA_W, 8, sample width in bits
ADDR_SIZE, 8, FIFO address width; counts are ADDR_SIZE+1 bits wide (max 2^ADDR_SIZE samples)
TIMEOUT_W, 16, width of the forced-trigger timeout counter (used only with the optional feature)

Ports:
clk_i  in  1  write-domain clock
rst_i  in  1  reset, synchronous, active-low
start_i  in  1  arm pulse; honoured only in IDLE or DONE
abort_i  in  1  return to IDLE from any state; highest priority
sample_i  in  DATA_W  ADC sample, unsigned
sample_valid_i  in  1  sample_i valid this cycle
trig_level_i  in  DATA_W  trigger threshold, unsigned; sampled every cycle
trig_rising_i  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
pre_cnt_i  in  ADDR_SIZE+1  pre-trigger sample count; latched on accepted start_i
post_cnt_i  in  ADDR_SIZE+1  post-trigger sample count, including the trigger sample; latched on accepted start_i
fifo_full_i  in  1  full flag from the FIFO write pointer
wr_en_o  out  1  FIFO write increment, combinational
wr_data_o  out  DATA_W  FIFO write data; equals sample_i
busy_o  out  1  state is PRE, WAIT_TRIG or POST
triggered_o  out  1  trigger seen in the current capture
done_o  out  1  state is DONE
overflow_o  out  1  sticky: a sample was dropped because the FIFO was full
forced_o  out  1  trigger was forced by timeout; tied 0 without the optional feature

Behaviour:
- Reset (rst_i low at posedge):
  - State goes to IDLE; all counters, prev_valid and the sticky flags clear.
  - All outputs read 0, except wr_data_o, which follows sample_i.
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- IDLE:
  - No writes.
  - start_i latches pre_cnt_i/post_cnt_i, clears the count, triggered_o, overflow_o, forced_o and prev_valid.
  - Then: PRE if latched pre > 0; else WAIT_TRIG.
- Write acceptance:
  - wr_en_o = sample_valid_i & ~fifo_full_i & (state==PRE | state==POST | trigger_hit in WAIT_TRIG).
  - Zero latency. Count increments at the posedge ending a cycle with wr_en_o=1.
- Dropped samples:
  - A valid sample in PRE/POST (or a trigger_hit sample) while fifo_full_i=1 is dropped.
  - overflow_o sets (sticky); the count does not increment.
- PRE: when a write brings the count to the latched pre value → WAIT_TRIG; count clears.
- WAIT_TRIG:
  - Nothing written except the trigger sample.
  - prev holds the last valid sample seen in WAIT_TRIG; prev_valid sets on the first one.
  - trigger_hit = sample_valid_i & prev_valid & (rising ? prev < level && sample >= level : prev > level && sample <= level).
  - On trigger_hit: triggered_o sets. If latched post == 0 → DONE and no write occurs; else the sample is written (count=1) and state goes to POST, or directly to DONE if latched post == 1.
  - A trigger_hit sample dropped while full still triggers; the count stays 0.
- POST: when a write brings the count to the latched post value → DONE.
- DONE:
  - done_o=1; other status flags hold their values.
  - start_i re-arms exactly as in IDLE.
- start_i while busy_o=1 is ignored.
- abort_i:
  - → IDLE next cycle from any state.
  - Clears done_o and busy_o; triggered_o and overflow_o hold.
  - wr_en_o is forced 0 in the abort cycle.
  - abort_i together with start_i → IDLE.
- Reset mid-capture behaves as abort, and additionally clears all status flags.
- Counts compare by equality; no wrap-around within one capture, since values are ≤ 2^ADDR_SIZE.

Optional Feature:
- Macro: CAPTURE_TRIG_TIMEOUT_EN.
- Defined:
  - Adds input timeout_i [TIMEOUT_W] (latched on start).
  - A cycle counter runs in WAIT_TRIG. If it reaches the latched timeout (nonzero) before trigger_hit, the next valid sample is treated as the trigger sample; forced_o and triggered_o set.
  - Timeout 0 disables the timeout.
- Undefined: timeout_i is absent; forced_o is constant 0; the block waits indefinitely.

Test Plan:
- Pre=4, post=4, rising, level=0x80, ramp 0x00,0x10,…,0xF0, no full → exactly 8 writes: 0x00,0x10,0x20,0x30, then 0x80,0x90,0xA0,0xB0; done_o=1; overflow_o=0.
- Pre=0, post=1, falling, level=0x40, samples 0x50,0x40 → single write of 0x40; PRE skipped; done_o rises on the cycle after the write.
- Pre=4, post=4, fifo_full_i=1 during the 3rd PRE sample → that sample is not written; overflow_o=1; 4 PRE writes still occur (PRE ends after the 5th valid sample).
- abort_i during POST after 2 writes → IDLE next cycle; busy_o=0; wr_en_o=0; a following start_i performs a full new capture.
- start_i pulsed in WAIT_TRIG → ignored; the latched counts are unchanged.
- With CAPTURE_TRIG_TIMEOUT_EN, timeout=10, constant samples 0x20, level=0x80 → forced trigger after 10 WAIT_TRIG cycles; forced_o=1; post samples written; done_o=1.

Source files
------------

// File: rtl/capture_ctrl.sv
// Write-side capture sequencer for the sample FIFO: pre-trigger fill, level-crossing trigger, post-trigger fill.
// Optional forced-trigger timeout is enabled by defining CAPTURE_TRIG_TIMEOUT_EN.
module capture_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [DATA_W-1:0]    sample_i,
  input  logic                 sample_valid_i,
  input  logic [DATA_W-1:0]    trig_level_i,
  input  logic                 trig_rising_i,
  input  logic [ADDR_SIZE:0]   pre_cnt_i,
  input  logic [ADDR_SIZE:0]   post_cnt_i,
  input  logic                 fifo_full_i,
`ifdef CAPTURE_TRIG_TIMEOUT_EN
  input  logic [TIMEOUT_W-1:0] timeout_i,
`endif
  output logic                 wr_en_o,
  output logic [DATA_W-1:0]    wr_data_o,
  output logic                 busy_o,
  output logic                 triggered_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic                 forced_o
);

  // state     | meaning
  // IDLE      | no capture armed, no writes
  // PRE       | writing pre-trigger samples
  // WAIT_TRIG | watching for a level crossing; only the trigger sample is written
  // POST      | writing post-trigger samples
  // DONE      | capture complete, status held until re-arm
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT_TRIG, S_POST, S_DONE} state_t;

  state_t               state;
  logic [ADDR_SIZE:0]   pre_lat, post_lat, cnt, cnt_inc;
  logic [DATA_W-1:0]    prev;
  logic                 prev_valid, triggered, overflow;
  logic                 trigger_hit, force_hit, trig_eff, wants_write, dropped;

  assign trigger_hit = sample_valid_i & prev_valid &
                       (trig_rising_i ? (prev < trig_level_i && sample_i >= trig_level_i)
                                      : (prev > trig_level_i && sample_i <= trig_level_i));

`ifdef CAPTURE_TRIG_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_lat, tmo_cnt;
  logic                 tmo_expired, forced;

  assign force_hit = sample_valid_i & tmo_expired & ~trigger_hit;
  assign forced_o  = forced;
`else
  assign force_hit = 1'b0;
  // timeout width has no use in this build; expression is constant 0
  assign forced_o  = (TIMEOUT_W < 0);
`endif

  assign trig_eff    = trigger_hit | force_hit;
  assign wants_write = sample_valid_i & ~abort_i &
                       (state == S_PRE || state == S_POST ||
                        (state == S_WAIT_TRIG && trig_eff && post_lat != '0));
  assign wr_en_o     = wants_write & ~fifo_full_i;
  assign dropped     = wants_write & fifo_full_i;
  assign wr_data_o   = sample_i;
  assign cnt_inc     = cnt + 1'b1;

  assign busy_o      = (state == S_PRE) || (state == S_WAIT_TRIG) || (state == S_POST);
  assign done_o      = (state == S_DONE);
  assign triggered_o = triggered;
  assign overflow_o  = overflow;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      pre_lat    <= '0;
      post_lat   <= '0;
      cnt        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      triggered  <= 1'b0;
      overflow   <= 1'b0;
`ifdef CAPTURE_TRIG_TIMEOUT_EN
      tmo_lat     <= '0;
      tmo_cnt     <= '0;
      tmo_expired <= 1'b0;
      forced      <= 1'b0;
`endif
    end else if (abort_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      if (dropped)
        overflow <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            pre_lat    <= pre_cnt_i;
            post_lat   <= post_cnt_i;
            cnt        <= '0;
            prev_valid <= 1'b0;
            triggered  <= 1'b0;
            overflow   <= 1'b0;
`ifdef CAPTURE_TRIG_TIMEOUT_EN
            tmo_lat     <= timeout_i;
            tmo_cnt     <= '0;
            tmo_expired <= 1'b0;
            forced      <= 1'b0;
`endif
            state <= (pre_cnt_i != '0) ? S_PRE : S_WAIT_TRIG;
          end
        end
        S_PRE: begin
          if (wr_en_o) begin
            if (cnt_inc == pre_lat) begin
              cnt   <= '0;
              state <= S_WAIT_TRIG;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_WAIT_TRIG: begin
          if (sample_valid_i) begin
            prev       <= sample_i;
            prev_valid <= 1'b1;
          end
`ifdef CAPTURE_TRIG_TIMEOUT_EN
          if (tmo_lat != '0 && !tmo_expired) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt + 1'b1 == tmo_lat)
              tmo_expired <= 1'b1;
          end
          if (force_hit)
            forced <= 1'b1;
`endif
          if (trig_eff) begin
            triggered <= 1'b1;
            if (post_lat == '0) begin
              state <= S_DONE;
            end else if (wr_en_o) begin
              cnt   <= cnt_inc;
              state <= (cnt_inc == post_lat) ? S_DONE : S_POST;
            end else begin
              // trigger sample lost to a full FIFO still counts as the trigger
              state <= S_POST;
            end
          end
        end
        S_POST: begin
          if (wr_en_o) begin
            cnt <= cnt_inc;
            if (cnt_inc == post_lat)
              state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed self-checking bench for capture_ctrl; the timeout scenario runs only when
// CAPTURE_TRIG_TIMEOUT_EN is defined.
module tb_capture_ctrl;
  localparam int DATA_W    = 8;
  localparam int ADDR_SIZE = 8;
  localparam int TIMEOUT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0, abort = 1'b0;
  logic [DATA_W-1:0]    sample = '0, level = '0;
  logic                 valid = 1'b0, rising = 1'b1, full = 1'b0;
  logic [ADDR_SIZE:0]   pre_cnt = '0, post_cnt = '0;
  logic [TIMEOUT_W-1:0] timeout = '0;
  logic                 wr_en, busy, triggered, done, overflow, forced;
  logic [DATA_W-1:0]    wr_data;

  int tests = 0;
  int fails = 0;
  int wcount = 0;
  logic [DATA_W-1:0] wlog [0:255];

  capture_ctrl #(.DATA_W(DATA_W), .ADDR_SIZE(ADDR_SIZE), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .sample_i(sample), .sample_valid_i(valid), .trig_level_i(level),
    .trig_rising_i(rising), .pre_cnt_i(pre_cnt), .post_cnt_i(post_cnt),
    .fifo_full_i(full),
`ifdef CAPTURE_TRIG_TIMEOUT_EN
    .timeout_i(timeout),
`endif
    .wr_en_o(wr_en), .wr_data_o(wr_data), .busy_o(busy), .triggered_o(triggered),
    .done_o(done), .overflow_o(overflow), .forced_o(forced)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so negedge sees a settled write strobe.
  always @(negedge clk) begin
    if (wr_en === 1'b1 && wcount < 256) begin
      wlog[wcount] <= wr_data;
      wcount       <= wcount + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [DATA_W-1:0] d);
    valid  = v;
    sample = d;
    @(posedge clk); #1;
  endtask

  task automatic arm(input logic [ADDR_SIZE:0] p, input logic [ADDR_SIZE:0] q,
                     input logic r, input logic [DATA_W-1:0] l);
    start = 1'b1; pre_cnt = p; post_cnt = q; rising = r; level = l;
    step(1'b0, 8'h00);
    start = 1'b0;
  endtask

  initial begin
    int base;
    logic [7:0] exp8;

    // reset
    repeat (2) step(1'b0, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_forced", forced, 0);
    chk("rst_wr_en", wr_en, 0);
    rst = 1'b1;
    step(1'b0, 8'h00);

    // 1: ramp, pre=4 post=4 rising at 0x80
    base = wcount;
    arm(9'd4, 9'd4, 1'b1, 8'h80);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i * 16));
    step(1'b0, 8'h00);
    chk("t1_nwr", wcount - base, 8);
    for (int i = 0; i < 8; i++) begin
      exp8 = (i < 4) ? 8'(i * 16) : 8'(8'h80 + (i - 4) * 16);
      chk($sformatf("t1_wr%0d", i), wlog[base + i], exp8);
    end
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_trig", triggered, 1);
    chk("t1_ovf", overflow, 0);

    // 2: re-arm from DONE, pre=0 post=1 falling at 0x40
    base = wcount;
    arm(9'd0, 9'd1, 1'b0, 8'h40);
    chk("t2_busy", busy, 1);
    chk("t2_trig_clr", triggered, 0);
    step(1'b1, 8'h50);
    chk("t2_no_wr", wcount - base, 0);
    valid = 1'b1; sample = 8'h40;
    #1;
    chk("t2_wr_en", wr_en, 1);
    chk("t2_done_before", done, 0);
    @(posedge clk); #1;
    chk("t2_done_after", done, 1);
    step(1'b0, 8'h00);
    chk("t2_nwr", wcount - base, 1);
    chk("t2_wr0", wlog[base], 8'h40);

    // 3: FIFO full on 3rd pre-trigger sample
    base = wcount;
    arm(9'd4, 9'd4, 1'b1, 8'h80);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    full = 1'b1;
    step(1'b1, 8'h03);
    full = 1'b0;
    chk("t3_ovf", overflow, 1);
    step(1'b1, 8'h04);
    step(1'b1, 8'h05);
    step(1'b1, 8'h10);
    chk("t3_pre_only", wcount - base, 4);
    step(1'b1, 8'h90);
    step(1'b1, 8'h91);
    step(1'b1, 8'h92);
    step(1'b1, 8'h93);
    step(1'b0, 8'h00);
    chk("t3_nwr", wcount - base, 8);
    chk("t3_wr2", wlog[base + 2], 8'h04);
    chk("t3_wr3", wlog[base + 3], 8'h05);
    chk("t3_wr4", wlog[base + 4], 8'h90);
    chk("t3_done", done, 1);
    chk("t3_ovf_hold", overflow, 1);

    // 4: abort during POST after two post writes, then a fresh capture
    base = wcount;
    arm(9'd1, 9'd4, 1'b1, 8'h80);
    chk("t4_ovf_clr", overflow, 0);
    step(1'b1, 8'h11);
    step(1'b1, 8'h20);
    step(1'b1, 8'h85);
    step(1'b1, 8'h86);
    abort = 1'b1; valid = 1'b1; sample = 8'h87;
    #1;
    chk("t4_abort_wr_en", wr_en, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_trig_hold", triggered, 1);
    step(1'b1, 8'h88);
    chk("t4_nwr", wcount - base, 3);
    base = wcount;
    arm(9'd4, 9'd4, 1'b1, 8'h80);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i * 16));
    step(1'b0, 8'h00);
    chk("t4_re_nwr", wcount - base, 8);
    chk("t4_re_wr7", wlog[base + 7], 8'hB0);
    chk("t4_re_done", done, 1);

    // 5: start while waiting for trigger is ignored
    base = wcount;
    arm(9'd2, 9'd3, 1'b1, 8'h80);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    start = 1'b1; pre_cnt = 9'd7; post_cnt = 9'd7;
    step(1'b1, 8'h10);
    start = 1'b0;
    chk("t5_busy", busy, 1);
    chk("t5_trig", triggered, 0);
    step(1'b1, 8'h90);
    step(1'b1, 8'h91);
    chk("t5_not_done", done, 0);
    step(1'b1, 8'h92);
    chk("t5_done", done, 1);
    step(1'b0, 8'h00);
    chk("t5_nwr", wcount - base, 5);
    chk("t5_wr2", wlog[base + 2], 8'h90);

`ifdef CAPTURE_TRIG_TIMEOUT_EN
    // 6: forced trigger after 10 cycles of flat input
    base = wcount;
    timeout = 16'd10;
    arm(9'd0, 9'd2, 1'b1, 8'h80);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h20);
    chk("t6_no_wr", wcount - base, 0);
    chk("t6_not_forced", forced, 0);
    step(1'b1, 8'h20);
    chk("t6_forced", forced, 1);
    chk("t6_trig", triggered, 1);
    step(1'b1, 8'h21);
    step(1'b0, 8'h00);
    chk("t6_nwr", wcount - base, 2);
    chk("t6_wr1", wlog[base + 1], 8'h21);
    chk("t6_done", done, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
